// File: rtl/exec_wb_unit.sv
// Execute/writeback stage of the 8-bit CPU: ALU, iterative shifter and iterative multiplier driving the RF write port.
// Build option: define EXEC_MUL_EN to get the 8-cycle shift-add multiply on op 7; without it op 7 is a NOP.
module exec_wb_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [2:0]        i_op,
   input  logic [ADDR_W-1:0] i_rd,
   input  logic [DATA_W-1:0] i_rs0_data,
   input  logic [DATA_W-1:0] i_rs1_data,
   output logic              RF_w_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [DATA_W-1:0] w_data,
   output logic              o_flag_z,
   output logic              o_flag_c,
   output logic              o_busy
);
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL} op_t;

   state_t            state;
   op_t               op_q;
   op_t               op_in;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] a_q;
   logic [2:0]        cnt_q;

   logic [DATA_W:0]   alu_res;
   logic              is_shift_in;
   logic              needs_exec;
   logic              is_nop;
   logic [DATA_W-1:0] sh_next;
   logic              sh_c;
   logic              wb_go;
   logic [ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0] wb_res;
   logic              wb_c;

   assign op_in       = op_t'(i_op);
   assign o_ready     = (state == IDLE);
   assign o_busy      = (state != IDLE);
   assign is_shift_in = (op_in == OP_SHL) || (op_in == OP_SHR);

`ifdef EXEC_MUL_EN
   // Right-shifting product register: mul_hi is the upper half, b_q doubles as the lower half.
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] mul_hi;
   logic [DATA_W:0]   mul_sum;
   assign mul_sum    = {1'b0, mul_hi} + (b_q[0] ? {1'b0, a_q} : {(DATA_W+1){1'b0}});
   assign is_nop     = 1'b0;
   assign needs_exec = (is_shift_in && (i_rs1_data[2:0] != 3'd0)) || (op_in == OP_MUL);
`else
   assign is_nop     = (op_in == OP_MUL);
   assign needs_exec = is_shift_in && (i_rs1_data[2:0] != 3'd0);
`endif

   // Single-cycle ops: MSB of alu_res is carry (ADD) or borrow (SUB).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      alu_res = {1'b0, i_rs0_data};
      case (op_in)
         OP_ADD:  alu_res = {1'b0, i_rs0_data} + {1'b0, i_rs1_data};
         OP_SUB:  alu_res = {1'b0, i_rs0_data} - {1'b0, i_rs1_data};
         OP_AND:  alu_res = {1'b0, i_rs0_data & i_rs1_data};
         OP_OR:   alu_res = {1'b0, i_rs0_data | i_rs1_data};
         OP_XOR:  alu_res = {1'b0, i_rs0_data ^ i_rs1_data};
         default: ;
      endcase
   end

   assign sh_next = (op_q == OP_SHL) ? {a_q[DATA_W-2:0], 1'b0} : {1'b0, a_q[DATA_W-1:1]};
   assign sh_c    = (op_q == OP_SHL) ? a_q[DATA_W-1] : a_q[0];

   // Selects the value presented at the WB entry edge.
   always_comb begin
      wb_go  = 1'b0;
      wb_rd  = i_rd;
      wb_res = alu_res[DATA_W-1:0];
      wb_c   = alu_res[DATA_W];
      case (state)
         IDLE: wb_go = i_valid && !needs_exec && !is_nop;
         EXEC: begin
            wb_go  = (cnt_q == 3'd0);
            wb_rd  = rd_q;
            wb_res = sh_next;
            wb_c   = sh_c;
`ifdef EXEC_MUL_EN
            if (op_q == OP_MUL) begin
               wb_res = {mul_sum[0], b_q[DATA_W-1:1]};
               wb_c   = |mul_sum[DATA_W:1];
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= OP_ADD;
         rd_q     <= '0;
         a_q      <= '0;
         cnt_q    <= '0;
         RF_w_en  <= 1'b0;
         w_addr   <= '0;
         w_data   <= '0;
         o_flag_z <= 1'b0;
         o_flag_c <= 1'b0;
`ifdef EXEC_MUL_EN
         b_q      <= '0;
         mul_hi   <= '0;
`endif
      end else begin
         // NOTE: sequential state uses nonblocking assignments only, so read-before-update order is irrelevant.
         RF_w_en <= 1'b0;
         if (wb_go) begin
            RF_w_en  <= (wb_rd != '0);
            w_addr   <= wb_rd;
            w_data   <= wb_res;
            o_flag_z <= (wb_res == '0);
            o_flag_c <= wb_c;
         end
         case (state)
            IDLE: if (i_valid) begin
               op_q  <= op_in;
               rd_q  <= i_rd;
               a_q   <= i_rs0_data;
               cnt_q <= is_shift_in ? (i_rs1_data[2:0] - 3'd1) : 3'(DATA_W - 1);
`ifdef EXEC_MUL_EN
               b_q    <= i_rs1_data;
               mul_hi <= '0;
`endif
               state <= needs_exec ? EXEC : WB;
            end
            EXEC: begin
               cnt_q <= cnt_q - 3'd1;
`ifdef EXEC_MUL_EN
               if (op_q == OP_MUL) begin
                  mul_hi <= mul_sum[DATA_W:1];
                  b_q    <= {mul_sum[0], b_q[DATA_W-1:1]};
               end else begin
                  a_q <= sh_next;
               end
`else
               a_q <= sh_next;
`endif
               if (cnt_q == 3'd0) state <= WB;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_exec_wb_unit.sv
// Randomized self-checking bench for exec_wb_unit against an arithmetic reference model with a behavioural RF.
module tb_exec_wb_unit;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
`ifdef EXEC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              i_valid;
   logic              o_ready;
   logic [2:0]        i_op;
   logic [ADDR_W-1:0] i_rd;
   logic [DATA_W-1:0] i_rs0_data;
   logic [DATA_W-1:0] i_rs1_data;
   logic              RF_w_en;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic              o_flag_z;
   logic              o_flag_c;
   logic              o_busy;

   int total = 0;
   int bad   = 0;

   // Expected output registers and model register file.
   int exp_addr = 0;
   int exp_data = 0;
   int exp_z    = 0;
   int exp_c    = 0;
   int mrf [8];
   logic [DATA_W-1:0] rf [8];

   always #5 clk = ~clk;

   always @(posedge clk) if (RF_w_en && (w_addr != '0)) rf[w_addr] <= w_data;

   exec_wb_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op), .i_rd(i_rd),
      .i_rs0_data(i_rs0_data), .i_rs1_data(i_rs1_data), .RF_w_en(RF_w_en), .w_addr(w_addr),
      .w_data(w_data), .o_flag_z(o_flag_z), .o_flag_c(o_flag_c), .o_busy(o_busy)
   );

   function automatic logic [DATA_W-1:0] rf_read(input int r);
      return (r == 0) ? 8'h00 : rf[r];
   endfunction

   // Reference: result, carry, number of EXEC cycles, and whether the op is a NOP.
   function automatic void model(input int op, input int a, input int b,
                                 output int res, output int c, output int lat, output bit nop);
      int n;
      int full;
      n = b % 8;
      res = 0; c = 0; lat = 0; nop = 1'b0;
      case (op)
         0: begin full = a + b; res = full % 256; c = (full > 255) ? 1 : 0; end
         1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: begin
            lat = n;
            if (n == 0) res = a;
            else begin res = (a * (1 << n)) % 256; c = (a >> (8 - n)) & 1; end
         end
         6: begin
            lat = n;
            if (n == 0) res = a;
            else begin res = a >> n; c = (a >> (n - 1)) & 1; end
         end
         default: begin
            if (MUL_EN) begin lat = 8; full = a * b; res = full % 256; c = (full > 255) ? 1 : 0; end
            else nop = 1'b1;
         end
      endcase
   endfunction

   // Issues one op in the first free cycle and checks busy window, WB cycle and outputs.
   task automatic run_op(input int op, input int rd, input int a_in, input int b_in,
                         input bit use_rf = 1'b0, input int rs0 = 0, input int rs1 = 0);
      int res, c, lat, a, b;
      bit nop, exp_wen;
      a = use_rf ? mrf[rs0] : a_in;
      b = use_rf ? mrf[rs1] : b_in;
      model(op, a, b, res, c, lat, nop);
      @(negedge clk);
      total++;
      if ({o_ready, o_busy, RF_w_en} !== 3'b100) begin
         bad++;
         $display("FAIL idle_before_issue op=%0d: ready/busy/wen=%b want=100", op, {o_ready, o_busy, RF_w_en});
      end
      i_valid    = 1'b1;
      i_op       = 3'(op);
      i_rd       = 3'(rd);
      i_rs0_data = use_rf ? rf_read(rs0) : 8'(a);
      i_rs1_data = use_rf ? rf_read(rs1) : 8'(b);
      @(negedge clk);
      for (int i = 0; i < lat; i++) begin
         total++;
         if ({o_ready, o_busy, RF_w_en} !== 3'b010) begin
            bad++;
            $display("FAIL exec_busy op=%0d cyc=%0d: ready/busy/wen=%b want=010", op, i, {o_ready, o_busy, RF_w_en});
         end
         // Scribble inputs and sometimes request while busy; none of it may be taken.
         i_valid    = 1'($urandom_range(0, 1));
         i_op       = 3'($urandom);
         i_rd       = 3'($urandom);
         i_rs0_data = 8'($urandom);
         i_rs1_data = 8'($urandom);
         @(negedge clk);
      end
      exp_wen = !nop && (rd != 0);
      if (!nop) begin
         exp_addr = rd; exp_data = res; exp_z = (res == 0) ? 1 : 0; exp_c = c;
      end
      if (exp_wen) mrf[rd] = res;
      total++;
      if ({o_ready, o_busy} !== 2'b01) begin
         bad++;
         $display("FAIL wb_busy op=%0d: ready/busy=%b want=01", op, {o_ready, o_busy});
      end
      total++;
      if (RF_w_en !== exp_wen) begin
         bad++;
         $display("FAIL wb_wen op=%0d rd=%0d: got=%b want=%b", op, rd, RF_w_en, exp_wen);
      end
      total++;
      if (w_addr !== 3'(exp_addr) || w_data !== 8'(exp_data)) begin
         bad++;
         $display("FAIL wb_data op=%0d a=%0h b=%0h: addr/data=%0d/%0h want=%0d/%0h", op, a, b, w_addr, w_data, exp_addr, exp_data);
      end
      total++;
      if ({o_flag_z, o_flag_c} !== {1'(exp_z), 1'(exp_c)}) begin
         bad++;
         $display("FAIL wb_flags op=%0d a=%0h b=%0h: zc=%b%b want=%0d%0d", op, a, b, o_flag_z, o_flag_c, exp_z, exp_c);
      end
      i_valid = 1'b0;
   endtask

   task automatic test_reset;
      bit wen_seen;
      rst = 1'b1; i_valid = 1'b0; i_op = '0; i_rd = '0; i_rs0_data = '0; i_rs1_data = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({RF_w_en, w_addr, w_data, o_flag_z, o_flag_c, o_ready, o_busy} !== {14'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL por_state: wen=%b addr=%0d data=%0h z=%b c=%b ready=%b busy=%b", RF_w_en, w_addr, w_data, o_flag_z, o_flag_c, o_ready, o_busy);
      end
      rst = 1'b0;
      run_op(1, 5, 8'h03, 8'h04);
      // Start a long op and hit reset in its 4th EXEC cycle.
      @(negedge clk);
      i_valid = 1'b1; i_op = MUL_EN ? 3'd7 : 3'd5; i_rd = 3'd4; i_rs0_data = 8'd5; i_rs1_data = 8'd7;
      @(negedge clk);
      i_valid  = 1'b0;
      wen_seen = RF_w_en;
      repeat (3) begin @(negedge clk); wen_seen |= RF_w_en; end
      rst = 1'b1;
      #1;
      total++;
      if ({o_ready, o_busy} !== 2'b10) begin
         bad++;
         $display("FAIL async_reset: ready/busy=%b want=10", {o_ready, o_busy});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (12) begin @(negedge clk); wen_seen |= RF_w_en; end
      total++;
      if (wen_seen !== 1'b0) begin
         bad++;
         $display("FAIL reset_abandon_wen: seen=%b want=0", wen_seen);
      end
      total++;
      if ({w_addr, w_data, o_flag_z, o_flag_c, o_ready} !== {13'd0, 1'b1}) begin
         bad++;
         $display("FAIL reset_abandon_state: addr=%0d data=%0h z=%b c=%b ready=%b", w_addr, w_data, o_flag_z, o_flag_c, o_ready);
      end
      exp_addr = 0; exp_data = 0; exp_z = 0; exp_c = 0;
   endtask

   task automatic test_directed;
      run_op(0, 3, 8'hF0, 8'h20);
      run_op(1, 2, 8'h05, 8'h05);
      run_op(1, 2, 8'h03, 8'h04);
      run_op(5, 1, 8'h81, 8'd3);
      run_op(6, 1, 8'h81, 8'd0);
      run_op(6, 6, 8'h81, 8'd1);
      run_op(5, 7, 8'h01, 8'hFF);
      run_op(7, 4, 8'h10, 8'h11);
      run_op(0, 0, 8'd1, 8'd1);
      run_op(3, 5, 8'h00, 8'h00);
   endtask

   task automatic test_back_to_back;
      int last_rd, rd, rs0, rs1;
      for (int r = 1; r < 8; r++) run_op(3, r, $urandom_range(0, 255), 0);
      last_rd = 7;
      for (int i = 0; i < 60; i++) begin
         rs0 = ($urandom_range(0, 1) == 1) ? last_rd : $urandom_range(0, 7);
         rs1 = $urandom_range(0, 7);
         rd  = $urandom_range(0, 7);
         run_op($urandom_range(0, 7), rd, 0, 0, 1'b1, rs0, rs1);
         last_rd = rd;
      end
      @(negedge clk);
      for (int r = 1; r < 8; r++) begin
         total++;
         if (rf[r] !== 8'(mrf[r])) begin
            bad++;
            $display("FAIL rf_contents r%0d: got=%0h want=%0h", r, rf[r], mrf[r]);
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 150; i++)
         run_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
      @(negedge clk);
      total++;
      if ({o_ready, o_busy, RF_w_en} !== 3'b100) begin
         bad++;
         $display("FAIL final_idle: ready/busy/wen=%b want=100", {o_ready, o_busy, RF_w_en});
      end
   endtask

   initial begin
      for (int r = 0; r < 8; r++) mrf[r] = 0;
      test_reset;
      test_directed;
      test_back_to_back;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
